rv32i_ctrl_alu_dmem: RTL and testbench



---
 rtl/rv32i_ctrl_alu_dmem.sv | 193 +++++++++++++++++++
 tb/tb_rv32i_ctrl_alu_dmem.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_ctrl_alu_dmem.sv
// Execute/memory slice of the rv32i single-cycle core: the control decoder, the 32-bit ALU
// and a word-addressed data memory with an init write port and a debug read port.
module rv32i_ctrl_alu_dmem #(
  parameter int DEPTH   = 256,
  parameter int INIT_AW = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic [2:0]         func3,
  input  logic [6:0]         func7,
  input  logic [31:0]        rs1,
  input  logic [31:0]        rs2,
  input  logic [31:0]        imm,
  input  logic               init_done,
  input  logic [INIT_AW-1:0] init_addr,
  input  logic [31:0]        init_dat,
  input  logic               init_enb,
  input  logic [INIT_AW-1:0] debug_addr,
  output logic               branch,
  output logic [2:0]         imm_src,
  output logic               mem_read,
  output logic               mem_2_reg,
  output logic               mem_write,
  output logic               alu_src,
  output logic               reg_write,
  output logic [3:0]         alu_ctrl,
  output logic [1:0]         wrt_back_src,
  output logic               second_u_type_add_src,
  output logic [31:0]        alu_results,
  output logic               alu_zero,
  output logic [31:0]        r_dat,
  output logic [31:0]        debug_data
);
  localparam int WA = $clog2(DEPTH);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_U   = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  logic        is_br;
  logic        br_on_zero;
  logic        jump;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] mem [DEPTH] = '{default: '0};

  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_fn = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  endfunction

  always_comb begin
    imm_src               = IMM_I;
    mem_read              = 1'b0;
    mem_2_reg             = 1'b0;
    mem_write             = 1'b0;
    alu_src               = 1'b0;
    reg_write             = 1'b0;
    alu_ctrl              = ALU_ADD;
    wrt_back_src          = WB_ALU;
    second_u_type_add_src = 1'b0;
    is_br                 = 1'b0;
    br_on_zero            = 1'b0;
    jump                  = 1'b0;
    if (!rst) begin
      case (opcode)
        7'b0110011: begin
          reg_write = 1'b1;
          alu_ctrl  = alu_fn(func3, func7[5]);
        end
        7'b0010011: begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          // ADDI has no subtract form, so func7[5] only matters for the right shift
          alu_ctrl  = alu_fn(func3, (func3 == 3'b101) && func7[5]);
        end
        7'b0000011: begin
          mem_read     = 1'b1;
          mem_2_reg    = 1'b1;
          reg_write    = 1'b1;
          alu_src      = 1'b1;
          wrt_back_src = WB_MEM;
        end
        7'b0100011: begin
          mem_write = 1'b1;
          alu_src   = 1'b1;
          imm_src   = IMM_S;
        end
        7'b1100011: begin
          imm_src = IMM_B;
          case (func3)
            3'b000: begin alu_ctrl = ALU_SUB;  is_br = 1'b1; br_on_zero = 1'b1; end
            3'b001: begin alu_ctrl = ALU_SUB;  is_br = 1'b1; end
            3'b100: begin alu_ctrl = ALU_SLT;  is_br = 1'b1; end
            3'b101: begin alu_ctrl = ALU_SLT;  is_br = 1'b1; br_on_zero = 1'b1; end
            3'b110: begin alu_ctrl = ALU_SLTU; is_br = 1'b1; end
            3'b111: begin alu_ctrl = ALU_SLTU; is_br = 1'b1; br_on_zero = 1'b1; end
            default: ;
          endcase
        end
        7'b1101111: begin
          jump         = 1'b1;
          reg_write    = 1'b1;
          wrt_back_src = WB_PC4;
          imm_src      = IMM_J;
        end
        7'b1100111: begin
          jump         = 1'b1;
          reg_write    = 1'b1;
          alu_src      = 1'b1;
          wrt_back_src = WB_PC4;
        end
        7'b0110111, 7'b0010111: begin
          reg_write             = 1'b1;
          wrt_back_src          = WB_U;
          imm_src               = IMM_U;
          second_u_type_add_src = opcode[5];
        end
        default: ;
      endcase
    end
  end

  assign branch = jump | (is_br & (br_on_zero ? alu_zero : ~alu_zero));

  assign op_b  = alu_src ? imm : rs2;
  assign shamt = op_b[4:0];

  always_comb begin
    case (alu_ctrl)
      ALU_ADD:  alu_results = rs1 + op_b;
      ALU_SUB:  alu_results = rs1 - op_b;
      ALU_AND:  alu_results = rs1 & op_b;
      ALU_OR:   alu_results = rs1 | op_b;
      ALU_XOR:  alu_results = rs1 ^ op_b;
      ALU_SLL:  alu_results = rs1 << shamt;
      ALU_SRL:  alu_results = rs1 >> shamt;
      ALU_SRA:  alu_results = $signed(rs1) >>> shamt;
      ALU_SLT:  alu_results = {31'b0, $signed(rs1) < $signed(op_b)};
      ALU_SLTU: alu_results = {31'b0, rs1 < op_b};
      default:  alu_results = 32'b0;
    endcase
  end

  assign alu_zero = (alu_results == 32'b0);

  // The write port is owned by the loader until init_done, then by the datapath
  logic          wr_en;
  logic [WA-1:0] wr_idx;
  logic [31:0]   wr_dat;

  assign wr_en  = init_done ? mem_write : init_enb;
  assign wr_idx = init_done ? alu_results[WA+1:2] : init_addr[WA+1:2];
  assign wr_dat = init_done ? rs2 : init_dat;

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_idx] <= wr_dat;
  end

  assign r_dat      = mem_read ? mem[alu_results[WA+1:2]] : 32'b0;
  assign debug_data = mem[debug_addr[WA+1:2]];

  logic unused_bits;
  assign unused_bits = ^{func7[6], func7[4:0], init_addr[1:0], debug_addr[1:0],
                         alu_results[31:WA+2], alu_results[1:0]};
endmodule

// File: tb/tb_rv32i_ctrl_alu_dmem.sv
// Bench for rv32i_ctrl_alu_dmem: directed scenarios with literal expectations, then random
// instructions checked every cycle against an instruction-level model and a memory array.
module tb_rv32i_ctrl_alu_dmem;
  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] rs1, rs2, imm;
  logic        init_done;
  logic [9:0]  init_addr;
  logic [31:0] init_dat;
  logic        init_enb;
  logic [9:0]  debug_addr;
  logic        branch;
  logic [2:0]  imm_src;
  logic        mem_read, mem_2_reg, mem_write, alu_src, reg_write;
  logic [3:0]  alu_ctrl;
  logic [1:0]  wrt_back_src;
  logic        second_u_type_add_src;
  logic [31:0] alu_results;
  logic        alu_zero;
  logic [31:0] r_dat;
  logic [31:0] debug_data;

  rv32i_ctrl_alu_dmem #(.DEPTH(256), .INIT_AW(10)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .rs1(rs1), .rs2(rs2), .imm(imm), .init_done(init_done), .init_addr(init_addr),
    .init_dat(init_dat), .init_enb(init_enb), .debug_addr(debug_addr),
    .branch(branch), .imm_src(imm_src), .mem_read(mem_read), .mem_2_reg(mem_2_reg),
    .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write), .alu_ctrl(alu_ctrl),
    .wrt_back_src(wrt_back_src), .second_u_type_add_src(second_u_type_add_src),
    .alu_results(alu_results), .alu_zero(alu_zero), .r_dat(r_dat), .debug_data(debug_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          done     = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] mm [256];

  typedef enum int {K_NONE, K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC} kind_t;
  typedef enum int {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
                    OP_SLT, OP_SLTU} aop_t;

  typedef struct packed {
    logic        branch;
    logic [2:0]  imm_src;
    logic        mem_read, mem_2_reg, mem_write, alu_src, reg_write;
    logic [3:0]  alu_ctrl;
    logic [1:0]  wb;
    logic        sec;
    logic [31:0] alu;
    logic        zero;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: instruction class -> mnemonic -> arithmetic
  function automatic kind_t kind_of(input logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      default:    return K_NONE;
    endcase
  endfunction

  function automatic aop_t arith_op(input kind_t k, input logic [2:0] f3, input logic [6:0] f7);
    if (k == K_R || k == K_I) begin
      case (f3)
        3'd0: return (k == K_R && f7[5]) ? OP_SUB : OP_ADD;
        3'd1: return OP_SLL;
        3'd2: return OP_SLT;
        3'd3: return OP_SLTU;
        3'd4: return OP_XOR;
        3'd5: return f7[5] ? OP_SRA : OP_SRL;
        3'd6: return OP_OR;
        default: return OP_AND;
      endcase
    end
    if (k == K_BR) begin
      if (f3 == 3'd0 || f3 == 3'd1) return OP_SUB;
      if (f3 == 3'd4 || f3 == 3'd5) return OP_SLT;
      if (f3 == 3'd6 || f3 == 3'd7) return OP_SLTU;
    end
    return OP_ADD;
  endfunction

  function automatic logic [3:0] code_of(input aop_t o);
    case (o)
      OP_ADD: return 4'b0000;  OP_SUB: return 4'b0001;  OP_AND: return 4'b0010;
      OP_OR:  return 4'b0011;  OP_XOR: return 4'b0100;  OP_SLL: return 4'b0101;
      OP_SRL: return 4'b0110;  OP_SRA: return 4'b0111;  OP_SLT: return 4'b1000;
      default: return 4'b1001;
    endcase
  endfunction

  function automatic logic [31:0] alu_ref(input aop_t o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << (b % 32);
      OP_SRL:  return a >> (b % 32);
      OP_SRA:  return 32'($signed(a) >>> (b % 32));
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model_now();
    exp_t  e;
    kind_t k;
    aop_t  o;
    e = '0;
    k = rst ? K_NONE : kind_of(opcode);
    case (k)
      K_R:     e.reg_write = 1'b1;
      K_I:     begin e.reg_write = 1'b1; e.alu_src = 1'b1; end
      K_LD:    begin e.mem_read = 1'b1; e.mem_2_reg = 1'b1; e.reg_write = 1'b1;
                     e.alu_src = 1'b1; e.wb = 2'b01; end
      K_ST:    begin e.mem_write = 1'b1; e.alu_src = 1'b1; e.imm_src = 3'b001; end
      K_BR:    e.imm_src = 3'b010;
      K_JAL:   begin e.branch = 1'b1; e.reg_write = 1'b1; e.wb = 2'b10; e.imm_src = 3'b011; end
      K_JALR:  begin e.branch = 1'b1; e.reg_write = 1'b1; e.wb = 2'b10; e.alu_src = 1'b1; end
      K_LUI:   begin e.reg_write = 1'b1; e.wb = 2'b11; e.sec = 1'b1; e.imm_src = 3'b100; end
      K_AUIPC: begin e.reg_write = 1'b1; e.wb = 2'b11; e.imm_src = 3'b100; end
      default: ;
    endcase
    o = arith_op(k, func3, func7);
    e.alu_ctrl = code_of(o);
    e.alu      = alu_ref(o, rs1, e.alu_src ? imm : rs2);
    e.zero     = (e.alu == 32'd0);
    if (k == K_BR) e.branch = br_taken(func3, rs1, rs2);
    return e;
  endfunction

  // memory model commits on the same edge as the DUT
  always @(posedge clk) begin : mem_model
    exp_t e;
    e = model_now();
    if (!rst) begin
      if (init_done) begin
        if (e.mem_write) mm[e.alu[9:2]] = rs2;
      end else if (init_enb) begin
        mm[init_addr[9:2]] = init_dat;
      end
    end
  end

  // scoreboard: every output, every cycle
  always @(negedge clk) begin : cmp
    exp_t        e;
    logic [31:0] er;
    if (!done) begin
      e  = model_now();
      er = e.mem_read ? mm[e.alu[9:2]] : 32'd0;
      chk("branch",    {31'd0, branch},    {31'd0, e.branch});
      chk("imm_src",   {29'd0, imm_src},   {29'd0, e.imm_src});
      chk("mem_read",  {31'd0, mem_read},  {31'd0, e.mem_read});
      chk("mem_2_reg", {31'd0, mem_2_reg}, {31'd0, e.mem_2_reg});
      chk("mem_write", {31'd0, mem_write}, {31'd0, e.mem_write});
      chk("alu_src",   {31'd0, alu_src},   {31'd0, e.alu_src});
      chk("reg_write", {31'd0, reg_write}, {31'd0, e.reg_write});
      chk("alu_ctrl",  {28'd0, alu_ctrl},  {28'd0, e.alu_ctrl});
      chk("wb_src",    {30'd0, wrt_back_src}, {30'd0, e.wb});
      chk("u_src",     {31'd0, second_u_type_add_src}, {31'd0, e.sec});
      chk("alu_res",   alu_results, e.alu);
      chk("alu_zero",  {31'd0, alu_zero},  {31'd0, e.zero});
      chk("r_dat",     r_dat, er);
      chk("debug",     debug_data, mm[debug_addr[9:2]]);
    end
  end

  // driver tasks
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    opcode = op; func3 = f3; func7 = f7; rs1 = a; rs2 = b; imm = im;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic after_neg();
    #2;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mm[i] = 32'd0;
    rst = 1'b1; init_done = 1'b0; init_addr = '0; init_dat = '0; init_enb = 1'b0;
    debug_addr = '0;
    drive(7'b0100011, 3'b010, 7'd0, 32'd0, 32'h1111_1111, 32'd8);

    // reset forces control off
    settle();
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_alu_src",   {31'd0, alu_src},   32'd0);
    chk("rst_imm_src",   {29'd0, imm_src},   32'd0);
    chk("rst_r_dat",     r_dat,              32'd0);
    after_neg();
    settle();
    after_neg();
    rst = 1'b0;
    drive(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0);

    // init load through the init port
    @(posedge clk); #1;
    init_enb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      init_addr = 10'(i * 4);
      init_dat  = 32'(i + 1);
      @(posedge clk); #1;
    end
    init_enb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      debug_addr = 10'(i * 4);
      exp_q.push_back(32'(i + 1));
      settle();
      chk("init_rd", debug_data, exp_q.pop_front());
      after_neg();
    end

    drive(7'b0000011, 3'b010, 7'd0, 32'd0, 32'd0, 32'd4);
    settle();
    chk("ld_mem_read", {31'd0, mem_read}, 32'd1);
    chk("ld_r_dat",    r_dat, 32'h0000_0002);
    chk("ld_wb",       {30'd0, wrt_back_src}, 32'd1);
    after_neg();

    drive(7'b0110111, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0);
    settle();
    chk("lui_rw",  {31'd0, reg_write}, 32'd1);
    chk("lui_wb",  {30'd0, wrt_back_src}, 32'd3);
    chk("lui_sec", {31'd0, second_u_type_add_src}, 32'd1);
    chk("lui_imm", {29'd0, imm_src}, 32'd4);
    after_neg();
    drive(7'b0010111, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0);
    settle();
    chk("auipc_sec", {31'd0, second_u_type_add_src}, 32'd0);
    chk("auipc_wb",  {30'd0, wrt_back_src}, 32'd3);
    chk("auipc_imm", {29'd0, imm_src}, 32'd4);
    after_neg();

    drive(7'b1100011, 3'b000, 7'd0, 32'd5, 32'd5, 32'd0);
    settle();
    chk("beq_zero",   {31'd0, alu_zero}, 32'd1);
    chk("beq_branch", {31'd0, branch},   32'd1);
    after_neg();
    drive(7'b1100011, 3'b001, 7'd0, 32'd5, 32'd5, 32'd0);
    settle();
    chk("bne_branch", {31'd0, branch}, 32'd0);
    after_neg();
    drive(7'b1100011, 3'b100, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    settle();
    chk("blt_branch", {31'd0, branch}, 32'd1);
    after_neg();
    drive(7'b1100011, 3'b110, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    settle();
    chk("bltu_branch", {31'd0, branch}, 32'd0);
    after_neg();

    // store becomes visible only after the edge
    init_done  = 1'b1;
    debug_addr = 10'd8;
    drive(7'b0100011, 3'b010, 7'd0, 32'd0, 32'hDEAD_BEEF, 32'd8);
    #1;
    chk("sw_before_edge", debug_data, 32'h0000_0003);
    settle();
    chk("sw_after_edge", debug_data, 32'hDEAD_BEEF);
    after_neg();
    drive(7'b0000011, 3'b010, 7'd0, 32'd0, 32'd0, 32'd8);
    settle();
    chk("lw_r_dat", r_dat, 32'hDEAD_BEEF);
    after_neg();

    drive(7'b0110011, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4, 32'd0);
    settle();
    chk("sra", alu_results, 32'hF800_0000);
    after_neg();
    drive(7'b0110011, 3'b000, 7'b0100000, 32'd0, 32'd1, 32'd0);
    settle();
    chk("sub", alu_results, 32'hFFFF_FFFF);
    after_neg();
    drive(7'b0110011, 3'b000, 7'd0, 32'h7FFF_FFFF, 32'd1, 32'd0);
    settle();
    chk("add_wrap", alu_results, 32'h8000_0000);
    after_neg();
    drive(7'b0110011, 3'b001, 7'd0, 32'd1, 32'd33, 32'd0);
    settle();
    chk("sll33", alu_results, 32'd2);
    after_neg();

    // store under reset must not land
    rst = 1'b1;
    drive(7'b0100011, 3'b010, 7'd0, 32'd0, 32'h1234_5678, 32'd8);
    settle();
    chk("rst_sw_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_sw_r_dat",     r_dat, 32'd0);
    chk("rst_sw_debug",     debug_data, 32'hDEAD_BEEF);
    after_neg();
    rst = 1'b0;
    drive(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0);
    settle();
    chk("post_rst_keep", debug_data, 32'hDEAD_BEEF);
    after_neg();

    // random instructions
    for (int n = 0; n < 3000; n++) begin
      logic [6:0] ops [10];
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000};
      rst    = ($urandom_range(0, 24) == 0);
      opcode = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
      func3  = 3'($urandom);
      func7  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : {1'b0, 1'($urandom), 5'd0};
      rs1    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 1023)) : $urandom;
      rs2    = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
      imm    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 1023)) : $urandom;
      if ($urandom_range(0, 49) == 0) init_done = ~init_done;
      init_enb   = 1'($urandom);
      init_addr  = 10'($urandom);
      init_dat   = $urandom;
      debug_addr = 10'($urandom);
      settle();
      after_neg();
    end

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
